regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Issue-side controller for the 32x32 register file: tracks registers with writes in flight and stalls issue on RAW/WAW hazards.
//  Sits between decode and the register-file read stage; the writeback stage retires entries through the wb port.
//  A writeback retiring a register is visible to issue in the same cycle, matching the register file's write-through read.
// PARAMETERS
//  NREGS   32  number of architectural registers; register 0 is hardwired zero
//  AW      5   register index width, clog2(NREGS)
//  OUTW    6   outstanding-write counter width, clog2(NREGS)+1
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      synchronous reset, active high
//  issue_valid   in   1      decode presents an instruction
//  issue_ready   out  1      scoreboard accepts it; issue fires on valid&&ready
//  issue_rs      in   AW     source register 1
//  issue_rt      in   AW     source register 2
//  issue_rt_use  in   1      instruction reads rt (0 for I-type ALU ops)
//  issue_rd      in   AW     destination register
//  issue_rd_we   in   1      instruction writes rd
//  wb_valid      in   1      writeback retires a write this cycle
//  wb_rd         in   AW     register being retired
//  flush         in   1      pipeline flush: discard all in-flight writes
//  busy          out  NREGS  registered pending-write bitmap; bit 0 always 0
//  outstanding   out  OUTW   registered popcount of busy
//  wb_err        out  1      sticky: wb_valid seen on a register that is not busy
// BEHAVIOUR
//  Reset: busy=0, outstanding=0, wb_err=0; issue_ready is combinational and evaluates to 1 once rst is low.
//  eff_busy = busy & ~(wb_valid ? onehot(wb_rd) : 0). This is the same-cycle retire bypass.
//  issue_ready = !flush && !rst && !eff_busy[rs] && !(issue_rt_use && eff_busy[rt]) && !(issue_rd_we && eff_busy[rd]).
//  Index 0 is never busy, so reads/writes of register 0 never stall; issue with rd=0 sets nothing.
//  On clk, in priority order:
//  - rst: all state cleared.
//  - flush: busy<=0, outstanding<=0; wb and issue that cycle are ignored; wb_err unchanged.
//  - otherwise apply the wb clear first, then the issue set. If both hit the same reg, set wins (busy stays 1, outstanding unchanged).
//  outstanding: +1 on set of a non-busy reg, -1 on clear; set+clear in the same cycle gives net 0.
//  wb_valid with busy[wb_rd]==0 (or wb_rd==0): no state change; wb_err<=1 until rst.
//  Latency: issue at cycle N sets busy[rd] visible at N+1; wb at N frees issue at N (bypass).
//  No back-to-back limit: one issue and one retire per cycle max.
//  issue_ready must not depend on issue_valid (no comb loop with decode).
// CONFIGURATION
//  SCOREBOARD_STATS_EN defined adds:
//  - stall_cycles (out, 32): counts cycles with issue_valid && !issue_ready && !flush; saturates at all-ones; reset 0.
//  - issue_count (out, 32): counts accepted issues; wraps; reset 0.
//  Without the macro, these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package regfile_pkg: NREGS, AW, REG_ZERO=5'd0, typedef reg_idx_t [AW-1:0], typedef reg_mask_t [NREGS-1:0].
//  Sub-module sb_stat_counter (width param, saturate/wrap select), instantiated twice under SCOREBOARD_STATS_EN.
//  Core bitmap, bypass and ready logic stay in regfile_scoreboard.
// TESTING
//  1 Reset then issue rd=8 we=1 -> next cycle busy=0x100, outstanding=1; then rs=8 issue -> issue_ready=0.
//  2 busy[8]=1; same cycle wb_rd=8 and issue rs=8 -> issue_ready=1, accepted; next cycle busy[8]=0.
//  3 busy[9]=1; issue rd=9 (WAW) while wb_rd=9 -> accepted; next cycle busy[9]=1, outstanding unchanged.
//  4 Issue rd=0 we=1 then rs=0 -> never stalls, busy stays 0, outstanding 0.
//  5 Set regs 8,10,12; assert flush with issue_valid rd=13 -> next cycle busy=0, outstanding=0, reg 13 not set.
//  6 wb_valid wb_rd=14 with busy=0 -> wb_err=1 and held; with STATS_EN, 3 stall cycles -> stall_cycles=3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes and types for the register-file issue scoreboard.
// Contents: register count and index widths, the outstanding-counter width,
// the statistics counter width, index/mask typedefs and a one-hot helper.
package regfile_pkg;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned OUTW   = 6;
    localparam int unsigned STAT_W = 32;

    typedef logic [AW-1:0]    reg_idx_t;
    typedef logic [NREGS-1:0] reg_mask_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // One-hot mask selecting a single register index.
    function automatic reg_mask_t onehot(input reg_idx_t idx);
        onehot = reg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/sb_stat_counter.sv
// Event counter used by the scoreboard statistics.
// Parameters:
//   WIDTH    counter width
//   SATURATE 1: hold at all-ones once reached; 0: wrap to zero
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous reset, active high
//   inc    count one event this cycle
//   count  registered counter value
module sb_stat_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Counter register; saturation only applies when the parameter selects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            if (SATURATE && (&count)) begin
                count <= count;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard for the 32x32 register file. Tracks registers with
// writes in flight and stalls issue on RAW/WAW hazards. A writeback retiring
// a register is visible to issue in the same cycle, matching the register
// file's write-through read.
// Optional feature macro: SCOREBOARD_STATS_EN adds stall/issue counters.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   issue_valid    decode presents an instruction
//   issue_ready    combinational accept; issue fires on valid && ready
//   issue_rs/rt    source registers; issue_rt_use qualifies rt
//   issue_rd       destination register; issue_rd_we qualifies it
//   wb_valid/wb_rd writeback retire of one register
//   flush          discard all in-flight writes
//   busy           registered pending-write bitmap (bit 0 always 0)
//   outstanding    registered count of busy registers
//   wb_err         sticky flag: retire of a register that was not busy
//   stall_cycles   (stats only) saturating count of stalled issue cycles
//   issue_count    (stats only) wrapping count of accepted issues
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [AW-1:0]     issue_rs,
    input  logic [AW-1:0]     issue_rt,
    input  logic              issue_rt_use,
    input  logic [AW-1:0]     issue_rd,
    input  logic              issue_rd_we,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic              flush,
    output logic [NREGS-1:0]  busy,
    output logic [OUTW-1:0]   outstanding,
    output logic              wb_err
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] issue_count
`endif
);

    reg_mask_t wb_mask_c;
    reg_mask_t eff_busy_c;
    reg_mask_t clr_mask_c;
    reg_mask_t set_mask_c;
    reg_mask_t after_clr_c;
    reg_mask_t busy_next_c;
    logic      fire_c;
    logic      wb_hit_c;
    logic      set_new_c;

    // Same-cycle retire bypass: a register being written back is already free.
    always_comb begin
        wb_mask_c  = wb_valid ? onehot(wb_rd) : '0;
        eff_busy_c = busy & ~wb_mask_c;
    end

    // Ready never looks at issue_valid, so there is no loop back into decode.
    assign issue_ready = !flush && !rst
                       && !eff_busy_c[issue_rs]
                       && !(issue_rt_use && eff_busy_c[issue_rt])
                       && !(issue_rd_we  && eff_busy_c[issue_rd]);

    assign fire_c = issue_valid && issue_ready;

    // Clear first, then set: a same-register retire+issue leaves it busy.
    always_comb begin
        wb_hit_c    = wb_valid && (wb_rd != REG_ZERO) && busy[wb_rd];
        clr_mask_c  = wb_hit_c ? onehot(wb_rd) : '0;
        set_mask_c  = (fire_c && issue_rd_we && (issue_rd != REG_ZERO))
                    ? onehot(issue_rd) : '0;
        after_clr_c = busy & ~clr_mask_c;
        set_new_c   = |(set_mask_c & ~after_clr_c);
        busy_next_c = (after_clr_c | set_mask_c) & ~reg_mask_t'(1);
    end

    // Bitmap, outstanding count and sticky error; flush leaves wb_err alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
            wb_err      <= 1'b0;
        end else if (flush) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            busy        <= busy_next_c;
            outstanding <= outstanding + OUTW'(set_new_c) - OUTW'(wb_hit_c);
            if (wb_valid && !wb_hit_c) begin
                wb_err <= 1'b1;
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic stall_c;

    assign stall_c = issue_valid && !issue_ready && !flush;

    sb_stat_counter #(
        .WIDTH    (STAT_W),
        .SATURATE (1'b1)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_c),
        .count (stall_cycles)
    );

    sb_stat_counter #(
        .WIDTH    (STAT_W),
        .SATURATE (1'b0)
    ) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fire_c),
        .count (issue_count)
    );
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed hazard scenarios then
// randomized traffic, checked through an expectation queue against a
// register-level behavioural model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_rt_use;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy;
    logic [5:0]  outstanding;
    logic        wb_err;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] issue_count;
`endif

    regfile_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rt_use (issue_rt_use),
        .issue_rd     (issue_rd),
        .issue_rd_we  (issue_rd_we),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy         (busy),
        .outstanding  (outstanding),
        .wb_err       (wb_err)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .issue_count  (issue_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ready;
        logic [31:0] busy;
        int          outst;
        bit          err;
        int unsigned stall;
        int unsigned icnt;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    // Reference model: which registers have a write pending, plus counters.
    bit          pend [32];
    bit          m_err;
    int unsigned m_stall;
    int unsigned m_icnt;

    function automatic bit blocked(input logic [4:0] r, input bit wv, input logic [4:0] wr);
        return (r != 5'd0) && pend[r] && !(wv && (wr == r));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push what the DUT should show for it.
    task automatic drive(input bit r, input bit v, input logic [4:0] rs_i, input logic [4:0] rt_i,
                         input bit rtu, input logic [4:0] rd_i, input bit we, input bit wv,
                         input logic [4:0] wr_i, input bit fl);
        exp_t e;
        bit   rdy;
        bit   fire;
        int   n;
        logic [31:0] b;
        @(negedge clk);
        rst          = r;
        issue_valid  = v;
        issue_rs     = rs_i;
        issue_rt     = rt_i;
        issue_rt_use = rtu;
        issue_rd     = rd_i;
        issue_rd_we  = we;
        wb_valid     = wv;
        wb_rd        = wr_i;
        flush        = fl;

        rdy  = !r && !fl && !blocked(rs_i, wv, wr_i)
             && !(rtu && blocked(rt_i, wv, wr_i))
             && !(we && blocked(rd_i, wv, wr_i));
        fire = v && rdy;

        if (r) begin
            foreach (pend[i]) pend[i] = 1'b0;
            m_err   = 1'b0;
            m_stall = 0;
            m_icnt  = 0;
        end else begin
            if (v && !rdy && !fl && (m_stall != 32'hffff_ffff)) m_stall++;
            if (fire) m_icnt++;
            if (fl) begin
                foreach (pend[i]) pend[i] = 1'b0;
            end else begin
                if (wv) begin
                    if ((wr_i != 5'd0) && pend[wr_i]) pend[wr_i] = 1'b0;
                    else m_err = 1'b1;
                end
                if (fire && we && (rd_i != 5'd0)) pend[rd_i] = 1'b1;
            end
        end

        b = '0;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            b[i] = pend[i];
            if (pend[i]) n++;
        end
        e.ready = rdy;
        e.busy  = b;
        e.outst = n;
        e.err   = m_err;
        e.stall = m_stall;
        e.icnt  = m_icnt;
        q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'(8 + $urandom_range(0, 7));
    endfunction

    // Monitor: ready just before the edge, registered state just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("issue_ready", 32'(issue_ready), 32'(e.ready));
                @(posedge clk);
                #1;
                check("busy", busy, e.busy);
                check("outstanding", 32'(outstanding), 32'(e.outst));
                check("wb_err", 32'(wb_err), 32'(e.err));
`ifdef SCOREBOARD_STATS_EN
                check("stall_cycles", stall_cycles, e.stall);
                check("issue_count", issue_count, e.icnt);
`endif
            end
        end
    end

    initial begin
        bit          v, rtu, we, wv, fl, r;
        logic [4:0]  rs_i, rt_i, rd_i, wr_i;
        int          cand[$];

        checks       = 0;
        failures     = 0;
        m_err        = 1'b0;
        m_stall      = 0;
        m_icnt       = 0;
        foreach (pend[i]) pend[i] = 1'b0;
        rst          = 1'b1;
        issue_valid  = 1'b0;
        issue_rs     = '0;
        issue_rt     = '0;
        issue_rt_use = 1'b0;
        issue_rd     = '0;
        issue_rd_we  = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        flush        = 1'b0;

        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);

        // RAW stall after a write is issued to r8.
        drive(0, 1, 5'd0, 5'd0, 0, 5'd8, 1, 0, 5'd0, 0);
        drive(0, 1, 5'd8, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
        // Same-cycle retire of r8 releases the reader.
        drive(0, 1, 5'd8, 5'd0, 0, 5'd0, 0, 1, 5'd8, 0);
        // WAW on r9 while r9 retires: stays busy, count unchanged.
        drive(0, 1, 5'd0, 5'd0, 0, 5'd9, 1, 0, 5'd0, 0);
        drive(0, 1, 5'd0, 5'd0, 0, 5'd9, 1, 1, 5'd9, 0);
        // Register 0 never becomes busy and never stalls.
        drive(0, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0);
        drive(0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 5'd0, 0);
        // Flush wipes r8/r9/r10/r12 and blocks the r13 issue.
        drive(0, 1, 5'd0, 5'd0, 0, 5'd8,  1, 0, 5'd0, 0);
        drive(0, 1, 5'd0, 5'd0, 0, 5'd10, 1, 0, 5'd0, 0);
        drive(0, 1, 5'd0, 5'd0, 0, 5'd12, 1, 0, 5'd0, 0);
        drive(0, 1, 5'd0, 5'd0, 0, 5'd13, 1, 0, 5'd0, 1);
        idle();
        // Retire of an idle register sets the sticky error; then stall 3 times.
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 5'd14, 0);
        drive(0, 1, 5'd0, 5'd0, 0, 5'd20, 1, 0, 5'd0, 0);
        drive(0, 1, 5'd20, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
        drive(0, 1, 5'd0, 5'd20, 1, 5'd0, 0, 0, 5'd0, 0);
        drive(0, 1, 5'd0, 5'd0, 0, 5'd20, 1, 0, 5'd0, 0);
        idle();
        idle();

        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);

        for (int c = 0; c < 1500; c++) begin
            r    = ($urandom_range(0, 299) == 0);
            v    = ($urandom_range(0, 3) != 0);
            rs_i = pick_reg();
            rt_i = pick_reg();
            rtu  = $urandom_range(0, 1) == 1;
            rd_i = pick_reg();
            we   = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            cand.delete();
            foreach (pend[i]) if (pend[i]) cand.push_back(i);
            wv   = 1'b0;
            wr_i = 5'($urandom_range(0, 31));
            if ((cand.size() > 0) && ($urandom_range(0, 1) == 1)) begin
                wv   = 1'b1;
                wr_i = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 99) == 0) begin
                wv = 1'b1;
            end
            drive(r, v, rs_i, rt_i, rtu, rd_i, we, wv, wr_i, fl);
        end

        idle();
        repeat (3) @(negedge clk);
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
